// File: rtl/result_step_ctrl.sv
// Post-run result sequencer: lets the core run until it halts, then steps a 16-bit display
// through a block of data memory, one word per debounced button press.
module result_step_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned COUNT     = 10,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              button_i,
  input  logic              halt_i,
  output logic              cpu_run_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       out_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic              done_o
);

  localparam int unsigned       CntW     = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0]   DbLast   = CntW'(DB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(COUNT - 1);

  typedef enum logic [1:0] {StRun, StFetch, StWait, StShow} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              stable_q, stable_d;
  logic [CntW-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic              cpu_run_q, cpu_run_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       out_q, out_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;

  // Only the low half-word is displayed.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i;

  // Debounce: a level change is accepted after DB_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (db_cnt_q == DbLast) begin
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_run_d = cpu_run_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    out_d     = out_q;
    idx_d     = idx_q;
    done_d    = done_q;
    unique case (state_q)
      StRun: begin
        cpu_run_d = ~halt_i;
        if (halt_i) begin
          state_d = StFetch;
          rd_en_d = 1'b1;
          addr_d  = BaseAddr + idx_q;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        out_d   = mem_rdata_i[15:0];
        done_d  = 1'b1;
        state_d = StShow;
      end
      StShow: begin
        if (press_q) begin
          idx_d   = (idx_q == LastIdx) ? '0 : idx_q + ADDR_W'(1);
          state_d = StFetch;
          rd_en_d = 1'b1;
          addr_d  = BaseAddr + idx_d;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      sync_q    <= '0;
      stable_q  <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      cpu_run_q <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= BaseAddr;
      out_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], button_i};
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      cpu_run_q <= cpu_run_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign cpu_run_o   = cpu_run_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_addr_o  = addr_q;
  assign out_o       = out_q;
  assign idx_o       = idx_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_result_step_ctrl.sv
// Bench for result_step_ctrl: three configurations (base 0/count 10, base 1020/count 6,
// base 7/count 1) share button/halt; a memory model and index model predict every output.
module tb_result_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        button;
  logic        halt;
  logic        cpu_run [3];
  logic        rd_en   [3];
  logic [9:0]  addr    [3];
  logic [31:0] rdata   [3];
  logic [15:0] out     [3];
  logic [9:0]  idx     [3];
  logic        done    [3];

  logic [31:0] mem [3][1024];
  int          m_idx [3];
  logic [9:0]  exp_log [3][64];
  logic [9:0]  obs_log [3][64];
  int          exp_n [3];
  int          obs_n [3];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  result_step_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(0), .COUNT(10), .DB_CYCLES(3)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .button_i(button), .halt_i(halt), .cpu_run_o(cpu_run[0]),
    .mem_rd_en_o(rd_en[0]), .mem_addr_o(addr[0]), .mem_rdata_i(rdata[0]), .out_o(out[0]),
    .idx_o(idx[0]), .done_o(done[0]));

  result_step_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(1020), .COUNT(6), .DB_CYCLES(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .button_i(button), .halt_i(halt), .cpu_run_o(cpu_run[1]),
    .mem_rd_en_o(rd_en[1]), .mem_addr_o(addr[1]), .mem_rdata_i(rdata[1]), .out_o(out[1]),
    .idx_o(idx[1]), .done_o(done[1]));

  result_step_ctrl #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(7), .COUNT(1), .DB_CYCLES(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .button_i(button), .halt_i(halt), .cpu_run_o(cpu_run[2]),
    .mem_rd_en_o(rd_en[2]), .mem_addr_o(addr[2]), .mem_rdata_i(rdata[2]), .out_o(out[2]),
    .idx_o(idx[2]), .done_o(done[2]));

  function automatic int base_of(int k);
    case (k)
      0: return 0;
      1: return 1020;
      default: return 7;
    endcase
  endfunction

  function automatic int count_of(int k);
    case (k)
      0: return 10;
      1: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic logic [9:0] cur_addr(int k);
    return 10'((base_of(k) + m_idx[k]) % 1024);
  endfunction

  // Data is only valid the cycle after a read strobe; otherwise the port carries noise.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rdata[k] <= rd_en[k] ? mem[k][addr[k]] : $urandom();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (rd_en[k]) begin
          if (obs_n[k] < 64) obs_log[k][obs_n[k]] = addr[k];
          obs_n[k] = obs_n[k] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_fetch();
    for (int k = 0; k < 3; k++) begin
      if (exp_n[k] < 64) exp_log[k][exp_n[k]] = cur_addr(k);
      exp_n[k]++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_cpu_run%0d", tag, k), 32'(cpu_run[k]), 0);
      check($sformatf("%s_rd_en%0d", tag, k), 32'(rd_en[k]), 0);
      check($sformatf("%s_addr%0d", tag, k), 32'(addr[k]), 32'(base_of(k) % 1024));
      check($sformatf("%s_out%0d", tag, k), 32'(out[k]), 0);
      check($sformatf("%s_idx%0d", tag, k), 32'(idx[k]), 0);
      check($sformatf("%s_done%0d", tag, k), 32'(done[k]), 0);
    end
  endtask

  task automatic check_show(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_idx%0d", tag, k), 32'(idx[k]), 32'(m_idx[k]));
      check($sformatf("%s_out%0d", tag, k), 32'(out[k]), 32'(mem[k][cur_addr(k)][15:0]));
      check($sformatf("%s_done%0d", tag, k), 32'(done[k]), 1);
      check($sformatf("%s_cpu_run%0d", tag, k), 32'(cpu_run[k]), 0);
      check($sformatf("%s_reads%0d", tag, k), 32'(obs_n[k]), 32'(exp_n[k]));
    end
  endtask

  // Called at a negedge; the run must still be active when halt goes high.
  task automatic halt_seq();
    for (int k = 0; k < 3; k++) check($sformatf("pre_halt_run%0d", k), 32'(cpu_run[k]), 1);
    halt = 1'b1;
    @(posedge clk); #1;
    expect_fetch();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("halt_run%0d", k), 32'(cpu_run[k]), 0);
      check($sformatf("halt_rd_en%0d", k), 32'(rd_en[k]), 1);
      check($sformatf("halt_addr%0d", k), 32'(addr[k]), 32'(cur_addr(k)));
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("halt1_rd_en%0d", k), 32'(rd_en[k]), 0);
      check($sformatf("halt1_done%0d", k), 32'(done[k]), 0);
    end
    @(posedge clk); #1;
    check_show("halt2");
    @(negedge clk);
    halt = 1'b0;
  endtask

  task automatic do_press(input int hi, input int lo, input bit bounce, input bit accepted);
    if (bounce) begin
      button = 1'b1;
      repeat (2) @(negedge clk);
      button = 1'b0;
      @(negedge clk);
    end
    button = 1'b1;
    repeat (hi) @(negedge clk);
    button = 1'b0;
    repeat (lo) @(negedge clk);
    if (accepted) begin
      for (int k = 0; k < 3; k++) m_idx[k] = (m_idx[k] + 1) % count_of(k);
      expect_fetch();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    button = 1'b0;
    halt   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0;
      exp_n[k] = 0;
      obs_n[k] = 0;
      for (int a = 0; a < 1024; a++) mem[k][a] = $urandom();
    end
    for (int i = 0; i < 10; i++) mem[0][i] = 32'(3 + 2 * i);

    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check($sformatf("run_rise%0d", k), 32'(cpu_run[k]), 1);

    // A press while the core is still running must be discarded.
    @(negedge clk);
    do_press(6, 10, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("run_press_idx%0d", k), 32'(idx[k]), 0);
      check($sformatf("run_press_reads%0d", k), 32'(obs_n[k]), 0);
    end
    repeat (32) @(negedge clk);
    halt_seq();

    // Halt is ignored once the display phase has started.
    repeat (12) begin
      halt = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    halt = 1'b0;
    repeat (4) @(negedge clk);
    check_show("halt_ignored");

    repeat (4) begin
      do_press($urandom_range(5, 7), $urandom_range(5, 8), 1'b0, 1'b1);
      check_show("step_a");
    end

    // Asynchronous reset in the middle of the display phase.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) m_idx[k] = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check($sformatf("rerun_rise%0d", k), 32'(cpu_run[k]), 1);
    @(negedge clk);
    repeat (48) @(negedge clk);
    halt_seq();

    for (int p = 0; p < 13; p++) begin
      do_press($urandom_range(5, 7), $urandom_range(5, 8), (p == 5), 1'b1);
      check_show((p == 5) ? "bounce" : "step_b");
    end

    // A short glitch alone must never count as a press.
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
    check_show("glitch");

    for (int k = 0; k < 3; k++) begin
      check($sformatf("log_len%0d", k), 32'(obs_n[k]), 32'(exp_n[k]));
      for (int i = 0; i < exp_n[k] && i < obs_n[k] && i < 64; i++) begin
        check($sformatf("log%0d_%0d", k, i), 32'(obs_log[k][i]), 32'(exp_log[k][i]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_step_ctrl.md
# result_step_ctrl

Post-run result sequencer for the single-cycle RISC wrapper. It lets the processor run after reset and waits for its halt flag, then freezes it. It then steps a 16-bit display through a block of data memory, one word per debounced button press, wrapping after the last word. It sits between the board button, the processor core's run/halt pins, the data-memory debug read port and the 16-bit `out` LEDs.

## Interface
- `ADDR_W`, 10: data-memory word-address width.
- `DATA_W`, 32: data-memory word width.
- `BASE_ADDR`, 0: word address of the first displayed element.
- `COUNT`, 10: number of words displayed; legal range 1 to 2^ADDR_W.
- `DB_CYCLES`, 3: consecutive stable synchronized samples needed to accept a button level change; must be at least 1.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `button` in 1: raw, asynchronous push-button.
- `halt` in 1: processor halted; level signal, sampled only in RUN.
- `cpu_run` out 1: registered; processor clock-enable.
- `mem_rd_en` out 1: registered; one-cycle read strobe to the debug port.
- `mem_addr` out ADDR_W: registered debug-port read address.
- `mem_rdata` in DATA_W: debug-port data, valid exactly 1 cycle after the `mem_rd_en` cycle.
- `out` out 16: registered; `mem_rdata[15:0]` of the current element.
- `idx` out ADDR_W: registered; index of the displayed element.
- `done` out 1: registered; high once the first element is on `out`, stays high until reset.

## Operation
- Reset values: state RUN, `cpu_run`=0, `mem_rd_en`=0, `mem_addr`=BASE_ADDR, `out`=0, `idx`=0, `done`=0, synchronizer and debounce registers 0.
- Button path:
  - 2-flop synchronizer.
  - Debounce counter: while the synchronized level differs from the stable level, count up; when the count reaches DB_CYCLES the stable level flips and the counter clears. Any sample equal to the stable level clears the counter.
  - `press` is a 1-cycle pulse on each stable 0->1 transition.
- FSM:
  - RUN: `cpu_run`=1. When `halt`=1, go to FETCH and set `cpu_run`=0 in the same edge.
  - FETCH: `mem_rd_en`=1, `mem_addr`=BASE_ADDR+idx for exactly one cycle. Next state WAIT.
  - WAIT: capture `out`<=`mem_rdata[15:0]` and set `done`=1. Next state SHOW.
  - SHOW: hold all outputs.
    - On `press`, set idx<=(idx==COUNT-1) ? 0 : idx+1, then go to FETCH.
    - Without `press`, remain in SHOW.
- `press` pulses outside SHOW are discarded, not queued.
- `halt` is ignored outside RUN. `cpu_run` never returns to 1 without reset.
- Address arithmetic is modulo 2^ADDR_W; BASE_ADDR+COUNT-1 beyond the top wraps silently.
- When COUNT=1, every press re-fetches index 0.
- When `rst` is asserted in any state, all registers return to their reset values immediately. The processor restarts from RUN after release.

## Timing
- `cpu_run` rises on the first rising edge after `rst` deasserts.
- `halt` seen high at edge N:
  - `cpu_run`=0 and FETCH after edge N.
  - `mem_rd_en` high for the cycle N..N+1.
  - `out` and `done` valid after edge N+2.
- Button to press: a clean 0->1 on `button` yields `press` 2+DB_CYCLES edges later, ±1 edge for sampling phase.
  - Pulses shorter than DB_CYCLES synchronized cycles never produce `press`.
- Press to display: `press` at edge P gives FETCH after P, new `idx` after P, new `out` after P+2.
- Minimum press-to-press spacing is 2*DB_CYCLES+2 cycles (release also needs debounce). Presses arriving during FETCH/WAIT are lost.

## Test plan
- Reset: hold `rst`=0 mid-SHOW with `idx`=4 → all outputs at reset values immediately. After release, `cpu_run`=1 one edge later.
- Halt handshake:
  - Stimulus: assert `halt` 50 cycles after reset.
  - Required: `cpu_run` falls on the same edge; one `mem_rd_en` pulse at address 0.
  - Required: memory model returns 0x0000_0003, so `out`=0x0003 and `done`=1 two edges later.
- Stepping: memory preloaded 3,5,…,21 at addresses 0-9 (`out`=0x0003 before the presses). Ten clean presses of 5 cycles high / 5 low, DB_CYCLES=3.
  - Required: `out` sequence 5,7,…,21,3; `idx` wraps 9→0.
- Bounce: `button` glitches high for 2 cycles, then is held high 10 cycles.
  - Required: exactly one `mem_rd_en` pulse and `idx` +1 only.
- Ignored inputs:
  - Stimulus: press during RUN, plus `halt` toggling while in SHOW.
  - Required: no `idx` change and `cpu_run` stays 0.
- Offset and minimum count: BASE_ADDR=1020, COUNT=6, ADDR_W=10.
  - Required: addresses 1020-1023, 0, 1, then 1020.
  - Stimulus: COUNT=1, press.
  - Required: re-reads BASE_ADDR with `idx`=0.
